gf2m_mul_stream: RTL

- Parametrised digit-serial polynomial-basis multiplier over GF(2^M). Successor to the fixed 163-bit / 16-bit-word multiplier top.
- Operands a and b and the reduction polynomial g are streamed in as D-bit words, most-significant word (MSW) first. The product streams out the same way.
- Adds valid/ready handshakes on both sides, output backpressure, a last-word flag and a synchronous abort. Sits between the word-bus operand loader and the result collector in the ECC datapath.

---
 rtl/gf2m_mul_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gf2m_mul_stream.sv
// rtl/gf2m_mul_stream.sv - digit-serial GF(2^M) polynomial-basis multiplier, streamed MSW-first operands and product
module gf2m_mul_stream #(
  parameter int M = 163,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] a_in,
  input  logic [D-1:0] b_in,
  input  logic [D-1:0] g_in,
  output logic [D-1:0] po,
  output logic         po_valid,
  input  logic         po_ready,
  output logic         po_last
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MASK = ~({W{1'b1}} << M);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, g_q, g_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [W-1:0]   out_q, out_d;
  logic           po_valid_q, po_valid_d;
  logic           po_last_q, po_last_d;

  logic [CW-1:0]  idx;
  logic [W-1:0]   a_sh, b_sh, g_sh;
  logic [M-1:0]   acc_v;
  logic [D-1:0]   digit;
  logic           fb;
  logic           accept, out_fire;

  assign in_ready = !clr && (state_q == IDLE || state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign out_fire = po_valid_q && po_ready;
  assign po       = out_q[W-1 -: D];
  assign po_valid = po_valid_q;
  assign po_last  = po_last_q;

  // One b digit per clock: D Horner steps, reduce-then-add, MSB first.
  always_comb begin
    acc_v = acc_q;
    fb    = 1'b0;
    digit = b_q[W-1 -: D];
    for (int j = D - 1; j >= 0; j--) begin
      fb    = acc_v[M-1];
      acc_v = {acc_v[M-2:0], 1'b0} ^ (fb ? g_q[M-1:0] : '0);
      if (digit[j]) acc_v = acc_v ^ a_q[M-1:0];
    end
  end

  // A word taken in IDLE starts a fresh operand, so shift from zero there.
  always_comb begin
    idx  = (state_q == IDLE) ? '0 : cnt_q;
    a_sh = (((state_q == IDLE) ? '0 : a_q) << D) | W'(a_in);
    b_sh = (((state_q == IDLE) ? '0 : b_q) << D) | W'(b_in);
    g_sh = (((state_q == IDLE) ? '0 : g_q) << D) | W'(g_in);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    g_d        = g_q;
    acc_d      = acc_q;
    out_d      = out_q;
    po_valid_d = po_valid_q;
    po_last_d  = po_last_q;
    if (clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      acc_d      = '0;
      out_d      = '0;
      po_valid_d = 1'b0;
      po_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (int'(idx) == N - 1) begin
              a_d     = a_sh & MASK;
              b_d     = b_sh & MASK;
              g_d     = g_sh & MASK;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = MUL;
            end else begin
              a_d     = a_sh;
              b_d     = b_sh;
              g_d     = g_sh;
              cnt_d   = idx + 1'b1;
              state_d = LOAD;
            end
          end
        end
        MUL: begin
          acc_d = acc_v;
          b_d   = b_q << D;
          if (int'(cnt_q) == N - 1) begin
            out_d      = W'(acc_v);
            po_valid_d = 1'b1;
            po_last_d  = (N == 1);
            cnt_d      = '0;
            state_d    = OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        OUT: begin
          if (out_fire) begin
            if (po_last_q) begin
              out_d      = '0;
              cnt_d      = '0;
              po_valid_d = 1'b0;
              po_last_d  = 1'b0;
              state_d    = IDLE;
            end else begin
              out_d     = out_q << D;
              cnt_d     = cnt_q + 1'b1;
              po_last_d = (int'(cnt_q) == N - 2);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      g_q        <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      po_valid_q <= 1'b0;
      po_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      g_q        <= g_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      po_valid_q <= po_valid_d;
      po_last_q  <= po_last_d;
    end
  end

endmodule
